// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard stall (STALL_CYCLES bubbles) and branch flush; 1-cycle latency.
// stall holds PC and IF/ID upstream; optional write-back bypass compiled in with ID_EX_WB_BYPASS_EN.
module id_ex_stage #(
   parameter int STALL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic        id_uses_rt,
   input  logic [31:0] id_imm,
   input  logic [31:0] id_op1,
   input  logic [31:0] id_op2,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        id_mem_to_reg,
   input  logic        id_alu_src,
   input  logic        id_reg_dst,
   input  logic [3:0]  id_alu_op,
   input  logic        wb_en,
   input  logic [4:0]  wb_reg,
   input  logic [31:0] wb_data,
   input  logic        flush,
   output logic        stall,
   output logic        ex_valid,
   output logic [4:0]  ex_rs,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_rd,
   output logic [31:0] ex_imm,
   output logic [31:0] ex_op1,
   output logic [31:0] ex_op2,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_mem_to_reg,
   output logic        ex_alu_src,
   output logic        ex_reg_dst,
   output logic [3:0]  ex_alu_op
);

   typedef enum logic {RUN, STALL} state_t;

   localparam logic [2:0] CNT_INIT = 3'(STALL_CYCLES - 1);

   state_t      state, state_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic        haz;
   logic        bubble;
   logic [31:0] op1_dat, op2_dat;

   assign haz = ex_valid & ex_mem_read & id_valid & (ex_rt != 5'd0) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      bubble    = 1'b0;
      if (flush) begin
         bubble    = 1'b1;
         state_nxt = RUN;
         cnt_nxt   = 3'd0;
      end else if (state == STALL) begin
         stall   = 1'b1;
         bubble  = 1'b1;
         cnt_nxt = cnt - 3'd1;
         if (cnt == 3'd1) state_nxt = RUN;
      end else if (haz) begin
         stall  = 1'b1;
         bubble = 1'b1;
         if (STALL_CYCLES > 1) begin
            state_nxt = STALL;
            cnt_nxt   = CNT_INIT;
         end
      end
      // reset dominates: never request a hold while the pipeline is being cleared
      if (rst) stall = 1'b0;
   end

`ifdef ID_EX_WB_BYPASS_EN
   // a register written back this cycle is not yet visible in the register file read data
   assign op1_dat = (wb_en && wb_reg != 5'd0 && wb_reg == id_rs) ? wb_data : id_op1;
   assign op2_dat = (wb_en && wb_reg != 5'd0 && wb_reg == id_rt) ? wb_data : id_op2;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_en, wb_reg, wb_data};
   assign op1_dat   = id_op1;
   assign op2_dat   = id_op2;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         ex_valid      <= 1'b0;
         ex_rs         <= 5'd0;
         ex_rt         <= 5'd0;
         ex_rd         <= 5'd0;
         ex_imm        <= 32'd0;
         ex_op1        <= 32'd0;
         ex_op2        <= 32'd0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_reg_dst    <= 1'b0;
         ex_alu_op     <= 4'd0;
      end else begin
         ex_valid      <= id_valid;
         ex_rs         <= id_rs;
         ex_rt         <= id_rt;
         ex_rd         <= id_rd;
         ex_imm        <= id_imm;
         ex_op1        <= op1_dat;
         ex_op2        <= op2_dat;
         ex_reg_write  <= id_reg_write  & id_valid;
         ex_mem_read   <= id_mem_read   & id_valid;
         ex_mem_write  <= id_mem_write  & id_valid;
         ex_mem_to_reg <= id_mem_to_reg & id_valid;
         ex_alu_src    <= id_alu_src    & id_valid;
         ex_reg_dst    <= id_reg_dst    & id_valid;
         ex_alu_op     <= id_valid ? id_alu_op : 4'd0;
      end
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard control for the 5-stage MIPS pipeline. It sits directly downstream of the register file: it captures `op1`/`op2` from the register file together with the decoded instruction fields, and presents them registered to the EX stage. It detects load-use hazards against the instruction currently held in ID/EX, stalls IF/ID for a configurable number of cycles, and inserts bubbles. It also accepts a flush from branch resolution.

## Interface
Parameters:
- `STALL_CYCLES`, default 1: bubbles inserted per load-use hazard; legal range 1..7.

Ports (clock and reset first):
- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `id_valid`  in  1: the ID stage holds a real instruction.
- `id_rs`, `id_rt`, `id_rd`  in  5 each: decoded register fields.
- `id_uses_rt`  in  1: the instruction reads `rt` as a source.
- `id_imm`  in  32: sign-extended immediate.
- `id_op1`, `id_op2`  in  32: register file read data for `rs` and `rt`.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_alu_src`, `id_reg_dst`  in  1 each: decoded control bits.
- `id_alu_op`  in  4: ALU operation code.
- `wb_en`  in  1: write-back enable, the same signal that drives the register file `isWB`.
- `wb_reg`  in  5: write-back destination, the same signal as `write_reg`.
- `wb_data`  in  32: write-back data, the same signal as `write_data`.
- `flush`  in  1: branch taken or jump in EX; discard the ID instruction.
- `stall`  out  1: combinational; hold the PC and IF/ID while high.
- `ex_valid`  out  1: the EX stage holds a real instruction.
- `ex_rs`, `ex_rt`, `ex_rd`  out  5; `ex_imm`, `ex_op1`, `ex_op2`  out  32; `ex_*` control bits  out  registered copies of the inputs.

## Operation
- States:
  - RUN: normal flow.
  - STALL: additional bubble cycles. A 3-bit counter `cnt` tracks the remaining cycles.
- Hazard condition `haz`, evaluated only in RUN: `ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt))`.
- Per-cycle priority: `rst` > `flush` > STALL > `haz` > normal load.
- `rst`:
  - All `ex_*` outputs go to 0 and `ex_valid` goes to 0.
  - The state goes to RUN and `cnt` goes to 0.
- `flush`:
  - The block loads a bubble and forces RUN with `cnt` = 0.
  - `stall` = 0 in that cycle, even when `haz` or STALL would otherwise assert it.
- Bubble load:
  - `ex_valid` and all control bits go to 0.
  - Data fields (`ex_rs`, `ex_rt`, `ex_rd`, `ex_imm`, `ex_op1`, `ex_op2`) go to 0.
- RUN with `haz`:
  - `stall` = 1 and a bubble is loaded.
  - If `STALL_CYCLES` > 1: the state goes to STALL and `cnt` is set to `STALL_CYCLES`-1.
  - Otherwise the state stays RUN.
- STALL:
  - `stall` = 1 and a bubble is loaded.
  - `cnt` decrements each cycle.
  - When `cnt` == 1 the next state is RUN.
- Normal load:
  - All `id_*` fields are copied to `ex_*`.
  - `ex_valid` = `id_valid`.
  - When `id_valid` = 0, the control bits are forced to 0.
- The ID instruction is held upstream while `stall` = 1 and is re-presented unchanged. This block does not latch it.

## Timing
- Latency is one cycle from the ID inputs to the `ex_*` outputs.
- `stall` is combinational from the current state, `haz` and `flush`. It has no dependence on `wb_*`.
- Each load-use hazard costs exactly `STALL_CYCLES` stall cycles: the detection cycle plus `STALL_CYCLES`-1 cycles in STALL.
- A new hazard cannot be detected during STALL, because ID/EX holds a bubble then.
- `flush` during STALL aborts the stall in the same cycle.
- Reset asserted mid-stall takes effect at the next edge. `stall` is 0 while `rst` is high.
- Every output resets to 0.

## Configuration
- `ID_EX_WB_BYPASS_EN` defined: write-back bypass is compiled in.
  - On a normal load, when `wb_en` & `wb_reg` != 0 & `wb_reg` == `id_rs`, `ex_op1` takes `wb_data` instead of `id_op1`.
  - The same rule applies to `ex_op2` with `id_rt`.
  - This covers a write and a read to the same register in the same cycle.
- Not defined: `ex_op1`/`ex_op2` always take `id_op1`/`id_op2`, and the `wb_*` ports are unused.

## Test plan
- Reset: hold `rst` for 2 cycles with all inputs at random values -> every output is 0, `stall` = 0, state is RUN.
- Pass-through: `id_valid`=1, `id_rs`=2, `id_op1`=5, `id_op2`=7, `id_alu_op`=4'h2 -> the next cycle shows `ex_valid`=1, `ex_op1`=5, `ex_op2`=7, `ex_alu_op`=2.
- Load-use with `STALL_CYCLES`=1 and then 3:
  - Stimulus: EX holds `lw` with `ex_rt`=4; ID uses `id_rs`=4.
  - Response: `stall`=1 for exactly 1 and 3 cycles respectively, and `ex_valid`=0 for the same number of cycles.
  - After the stall, the ID instruction loads with `ex_valid`=1.
  - Repeat with `ex_rt`=0 -> no stall.
- `rt` sensitivity: `lw` with `ex_rt`=5, ID `id_rt`=5 and `id_uses_rt`=0 -> no stall. With `id_uses_rt`=1 -> stall.
- Flush mid-stall: `STALL_CYCLES`=3, assert `flush` in the 2nd stall cycle -> `stall`=0 that cycle, a bubble is loaded, and the next instruction is accepted the following cycle.
- Bypass: `wb_en`=1, `wb_reg`=3, `wb_data`=32'hDEAD_BEEF, `id_rs`=3, `id_op1`=7 -> with the macro, `ex_op1`=DEADBEEF; without it, `ex_op1`=7. With `wb_reg`=0 -> `ex_op1`=7 in both builds.
